// File: rtl/r_pipeline_core.sv
// Five-stage in-order R-type core: IF, ID/RF read, EX, MEM passthrough, WB.
// Full EX forwarding plus RF write-through, so dependent instructions never stall.
module r_pipeline_core #(
    parameter int XLEN    = 32,
    parameter int NREG    = 32,
    parameter int PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic [31:0]     imem_addr,
    input  logic [31:0]     imem_instr,
    input  logic            imem_valid,
    input  logic            stall,
    output logic            retire_valid,
    output logic [4:0]      retire_rd,
    output logic [XLEN-1:0] retire_data,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    function automatic logic reg_ok(input logic [4:0] a);
        return int'(a) < NREG;
    endfunction

    function automatic logic funct_ok(input logic [5:0] f);
        logic ok;
        case (f)
            F_SLL, F_SRL, F_SRA, F_ADD, F_SUB, F_AND,
            F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: ok = 1'b1;
            default:                           ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Shifts wider than XLEN fall out naturally: zeros for sll/srl, sign fill for sra.
    function automatic logic [XLEN-1:0] alu(input logic [5:0]      f,
                                            input logic [4:0]      sh,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        logic        [XLEN-1:0] r;
        sa = a;
        sb = b;
        r  = '0;
        case (f)
            F_ADD:  r = a + b;
            F_SUB:  r = a - b;
            F_AND:  r = a & b;
            F_OR:   r = a | b;
            F_XOR:  r = a ^ b;
            F_NOR:  r = ~(a | b);
            F_SLT:  r = {{(XLEN-1){1'b0}}, (sa < sb)};
            F_SLTU: r = {{(XLEN-1){1'b0}}, (a < b)};
            F_SLL:  r = b << sh;
            F_SRL:  r = b >> sh;
            F_SRA:  r = sb >>> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [31:0]     r_pc;
    logic [XLEN-1:0] r_rf [NREG];

    logic            r_vld_p1;
    logic [31:0]     r_instr_p1;

    logic            r_vld_p2;
    logic            r_wr_p2;
    logic [XLEN-1:0] r_a_p2;
    logic [XLEN-1:0] r_b_p2;
    logic [4:0]      r_rs_p2;
    logic [4:0]      r_rt_p2;
    logic [4:0]      r_rd_p2;
    logic [5:0]      r_fn_p2;
    logic [4:0]      r_sh_p2;

    logic            r_vld_p3;
    logic            r_wr_p3;
    logic [4:0]      r_rd_p3;
    logic [XLEN-1:0] r_res_p3;

    logic            r_vld_p4;
    logic            r_wr_p4;
    logic [4:0]      r_rd_p4;
    logic [XLEN-1:0] r_res_p4;

    // ---- ID: decode and register read (p1 -> p2) ----
    logic [5:0]      w_op_p1;
    logic [4:0]      w_rs_p1;
    logic [4:0]      w_rt_p1;
    logic [4:0]      w_rd_p1;
    logic [4:0]      w_sh_p1;
    logic [5:0]      w_fn_p1;
    logic            w_wr_p1;
    logic [XLEN-1:0] w_a_p1;
    logic [XLEN-1:0] w_b_p1;
    logic            w_fwd3;
    logic            w_fwd4;

    assign w_op_p1 = r_instr_p1[31:26];
    assign w_rs_p1 = r_instr_p1[25:21];
    assign w_rt_p1 = r_instr_p1[20:16];
    assign w_rd_p1 = r_instr_p1[15:11];
    assign w_sh_p1 = r_instr_p1[10:6];
    assign w_fn_p1 = r_instr_p1[5:0];
    assign w_wr_p1 = r_vld_p1 && (w_op_p1 == 6'd0) && funct_ok(w_fn_p1)
                     && (w_rd_p1 != 5'd0) && reg_ok(w_rd_p1);

    assign w_fwd3 = r_vld_p3 && r_wr_p3;
    assign w_fwd4 = r_vld_p4 && r_wr_p4;

    // The WB write lands on the same edge ID/EX captures, so bypass it here.
    always_comb begin
        w_a_p1 = '0;
        w_b_p1 = '0;
        if (w_rs_p1 != 5'd0 && reg_ok(w_rs_p1)) w_a_p1 = r_rf[w_rs_p1[IDXW-1:0]];
        if (w_rt_p1 != 5'd0 && reg_ok(w_rt_p1)) w_b_p1 = r_rf[w_rt_p1[IDXW-1:0]];
        if (w_fwd4 && r_rd_p4 == w_rs_p1) w_a_p1 = r_res_p4;
        if (w_fwd4 && r_rd_p4 == w_rt_p1) w_b_p1 = r_res_p4;
    end

    // ---- EX: forwarding and ALU (p2 -> p3) ----
    logic [XLEN-1:0] w_a_p2;
    logic [XLEN-1:0] w_b_p2;
    logic [XLEN-1:0] w_res_p2;

    assign w_a_p2 = (w_fwd3 && r_rd_p3 == r_rs_p2) ? r_res_p3 :
                    (w_fwd4 && r_rd_p4 == r_rs_p2) ? r_res_p4 : r_a_p2;
    assign w_b_p2 = (w_fwd3 && r_rd_p3 == r_rt_p2) ? r_res_p3 :
                    (w_fwd4 && r_rd_p4 == r_rt_p2) ? r_res_p4 : r_b_p2;
    assign w_res_p2 = alu(r_fn_p2, r_sh_p2, w_a_p2, w_b_p2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
            r_wr_p2  <= 1'b0;
            r_vld_p3 <= 1'b0;
            r_wr_p3  <= 1'b0;
            r_vld_p4 <= 1'b0;
            r_wr_p4  <= 1'b0;
        end else if (!stall) begin
            if (imem_valid) r_pc <= r_pc + 32'(PC_STEP);
            r_vld_p1 <= imem_valid;
            r_vld_p2 <= r_vld_p1;
            r_wr_p2  <= w_wr_p1;
            r_vld_p3 <= r_vld_p2;
            r_wr_p3  <= r_vld_p2 && r_wr_p2;
            r_vld_p4 <= r_vld_p3;
            r_wr_p4  <= r_vld_p3 && r_wr_p3;
        end
    end

    // Data registers need no reset: every consumer is qualified by the valid/write bits.
    always_ff @(posedge clk) begin
        if (!stall) begin
            r_instr_p1 <= imem_instr;
            r_a_p2     <= w_a_p1;
            r_b_p2     <= w_b_p1;
            r_rs_p2    <= w_rs_p1;
            r_rt_p2    <= w_rt_p1;
            r_rd_p2    <= w_rd_p1;
            r_fn_p2    <= w_fn_p1;
            r_sh_p2    <= w_sh_p1;
            r_rd_p3    <= r_rd_p2;
            r_res_p3   <= w_res_p2;
            r_rd_p4    <= r_rd_p3;
            r_res_p4   <= r_res_p3;
        end
    end

    // ---- WB: register file write (p4) ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
        end else if (!stall && w_fwd4) begin
            r_rf[r_rd_p4[IDXW-1:0]] <= r_res_p4;
        end
    end

    assign imem_addr    = r_pc;
    assign retire_valid = w_fwd4 && !stall;
    assign retire_rd    = w_fwd4 ? r_rd_p4 : 5'd0;
    assign retire_data  = w_fwd4 ? r_res_p4 : '0;
    assign dbg_data     = (dbg_addr != 5'd0 && reg_ok(dbg_addr)) ? r_rf[dbg_addr[IDXW-1:0]] : '0;

endmodule

// File: tb/tb_r_pipeline_core.sv
// Bench for r_pipeline_core: a 32-bit/32-reg and a 16-bit/8-reg instance share stimulus
// and are checked every cycle against an in-order instruction-level model.
module tb_r_pipeline_core;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        imem_valid = 1'b0;
    logic [4:0]  dbg_addr = 5'd0;
    logic [31:0] prog [64];

    logic [31:0] d_pc    [2];
    logic [31:0] d_instr [2];
    logic        d_rv    [2];
    logic [4:0]  d_rrd   [2];
    logic [31:0] d_rdata [2];
    logic [31:0] d_dbg   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int XL = (g == 0) ? 32 : 16;
        localparam int NR = (g == 0) ? 32 : 8;
        logic [XL-1:0] w_rdata;
        logic [XL-1:0] w_dbg;
        assign d_instr[g] = prog[d_pc[g][7:2]];
        r_pipeline_core #(.XLEN(XL), .NREG(NR), .PC_STEP(4)) u_dut (
            .clk          (clk),
            .rst          (rst),
            .imem_addr    (d_pc[g]),
            .imem_instr   (d_instr[g]),
            .imem_valid   (imem_valid),
            .stall        (stall),
            .retire_valid (d_rv[g]),
            .retire_rd    (d_rrd[g]),
            .retire_data  (w_rdata),
            .dbg_addr     (dbg_addr),
            .dbg_data     (w_dbg)
        );
        assign d_rdata[g] = 32'(w_rdata);
        assign d_dbg[g]   = 32'(w_dbg);
    end

    // ---------------- reference model ----------------
    bit          started = 1'b0;
    logic [31:0] m_pc   [2];
    logic [31:0] m_arch [2][32];
    logic [31:0] m_rf   [2][32];
    bit          sv     [2][4];
    logic [4:0]  srd    [2][4];
    logic [31:0] sdat   [2][4];

    function automatic int xl_of(input int c); return (c == 0) ? 32 : 16; endfunction
    function automatic int nr_of(input int c); return (c == 0) ? 32 : 8;  endfunction

    function automatic void exec(input int c, input logic [31:0] ins,
                                 output bit w, output logic [4:0] d, output logic [31:0] v);
        int     xl;
        longint mask, ua, ub, sa, sb, r;
        bit     ok;
        logic [4:0] rs, rt, sh;
        logic [5:0] fn;
        rs = ins[25:21]; rt = ins[20:16]; d = ins[15:11]; sh = ins[10:6]; fn = ins[5:0];
        xl   = xl_of(c);
        mask = (64'sd1 <<< xl) - 1;
        ua   = (int'(rs) < nr_of(c)) ? longint'(m_arch[c][rs]) : 0;
        ub   = (int'(rt) < nr_of(c)) ? longint'(m_arch[c][rt]) : 0;
        ua   = ua & mask;
        ub   = ub & mask;
        sa   = ua[xl-1] ? ua - (mask + 1) : ua;
        sb   = ub[xl-1] ? ub - (mask + 1) : ub;
        ok   = 1'b1;
        r    = 0;
        case (fn)
            6'h20: r = ua + ub;
            6'h22: r = ua - ub;
            6'h24: r = ua & ub;
            6'h25: r = ua | ub;
            6'h26: r = ua ^ ub;
            6'h27: r = ~(ua | ub);
            6'h2A: r = (sa < sb) ? 1 : 0;
            6'h2B: r = (ua < ub) ? 1 : 0;
            6'h00: r = ub << sh;
            6'h02: r = ub >> sh;
            6'h03: r = sb >>> sh;
            default: ok = 1'b0;
        endcase
        v = 32'(r & mask);
        w = (ins[31:26] == 6'd0) && ok && (d != 5'd0) && (int'(d) < nr_of(c));
    endfunction

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_pc[c] <= 32'd0;
                for (int i = 0; i < 32; i++) begin
                    m_arch[c][i] <= 32'd0;
                    m_rf[c][i]   <= 32'd0;
                end
                for (int k = 0; k < 4; k++) sv[c][k] <= 1'b0;
            end else if (!stall) begin
                bit w; logic [4:0] d; logic [31:0] v;
                if (sv[c][3]) m_rf[c][srd[c][3]] <= sdat[c][3];
                for (int k = 3; k > 0; k--) begin
                    sv[c][k]   <= sv[c][k-1];
                    srd[c][k]  <= srd[c][k-1];
                    sdat[c][k] <= sdat[c][k-1];
                end
                sv[c][0] <= 1'b0;
                if (imem_valid) begin
                    exec(c, prog[m_pc[c][7:2]], w, d, v);
                    sv[c][0]   <= w;
                    srd[c][0]  <= d;
                    sdat[c][0] <= v;
                    if (w) m_arch[c][d] <= v;
                    m_pc[c] <= m_pc[c] + 32'd4;
                end
            end
        end
        if (rst) started <= 1'b1;
    end

    // ---------------- compare process ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          lit_kind = 0;    // 0 none, 1 register via dbg, 2 pc, 3 retire_valid
    logic [31:0] lit_exp [2];

    task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cfg%0d t=%0t: got %h, expected %h", nm, c, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                for (int c = 0; c < 2; c++) begin
                    bit          erv;
                    logic [31:0] edbg;
                    erv  = sv[c][3] && !stall;
                    edbg = (dbg_addr != 5'd0 && int'(dbg_addr) < nr_of(c)) ? m_rf[c][dbg_addr] : 32'd0;
                    check("imem_addr", c, d_pc[c], m_pc[c]);
                    check("retire_valid", c, 32'(d_rv[c]), 32'(erv));
                    if (erv) begin
                        check("retire_rd", c, 32'(d_rrd[c]), 32'(srd[c][3]));
                        check("retire_data", c, d_rdata[c], sdat[c][3]);
                    end
                    check("dbg_data", c, d_dbg[c], edbg);
                    if (lit_kind == 1) check("lit_reg", c, d_dbg[c], lit_exp[c]);
                    if (lit_kind == 2) check("lit_pc", c, d_pc[c], lit_exp[c]);
                    if (lit_kind == 3) check("lit_retire", c, 32'(d_rv[c]), lit_exp[c]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] rinst(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    task automatic cyc(input bit r, input bit s, input bit v, input int kind,
                       input logic [4:0] a, input logic [31:0] e0, input logic [31:0] e1);
        rst        = r;
        stall      = s;
        imem_valid = v;
        lit_kind   = kind;
        lit_exp[0] = e0;
        lit_exp[1] = e1;
        dbg_addr   = (kind == 1) ? a : 5'($urandom_range(0, 31));
        @(posedge clk);
        #1;
        lit_kind = 0;
    endtask

    task automatic run(input bit s, input bit v, input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, s, v, 0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 0, 5'd0, 32'd0, 32'd0);
        cyc(1'b1, 1'b1, 1'b1, 0, 5'd0, 32'd0, 32'd0);
    endtask

    task automatic lit_reg(input logic [4:0] a, input logic [31:0] e0, input logic [31:0] e1);
        cyc(1'b0, 1'b1, 1'b0, 1, a, e0, e1);
    endtask

    task automatic load_chain(input logic [4:0] srl_amt);
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        prog[0] = rinst(6'h27, 5'd0, 5'd0, 5'd1, 5'd0);     // nor $1,$0,$0
        prog[1] = rinst(6'h02, 5'd0, 5'd1, 5'd2, srl_amt);  // srl $2,$1,amt
        prog[2] = rinst(6'h20, 5'd2, 5'd2, 5'd3, 5'd0);     // add $3,$2,$2
        prog[3] = rinst(6'h22, 5'd3, 5'd1, 5'd4, 5'd0);     // sub $4,$3,$1
        prog[4] = rinst(6'h03, 5'd0, 5'd1, 5'd5, 5'd31);    // sra $5,$1,31
        prog[5] = rinst(6'h2A, 5'd1, 5'd0, 5'd6, 5'd0);     // slt $6,$1,$0
        prog[6] = rinst(6'h2B, 5'd1, 5'd0, 5'd7, 5'd0);     // sltu $7,$1,$0
        prog[7] = rinst(6'h20, 5'd1, 5'd1, 5'd0, 5'd0);     // add $0,$1,$1
        prog[8] = {6'h23, 5'd1, 5'd1, 5'd8, 5'd0, 6'h20};   // non-R opcode
    endtask

    task automatic check_chain28();
        lit_reg(5'd1, 32'hFFFF_FFFF, 32'h0000_FFFF);
        lit_reg(5'd2, 32'h0000_000F, 32'h0000_0000);
        lit_reg(5'd3, 32'h0000_001E, 32'h0000_0000);
        lit_reg(5'd4, 32'h0000_001F, 32'h0000_0001);
        lit_reg(5'd5, 32'hFFFF_FFFF, 32'h0000_FFFF);
        lit_reg(5'd6, 32'h0000_0001, 32'h0000_0001);
        lit_reg(5'd7, 32'h0000_0000, 32'h0000_0000);
        lit_reg(5'd0, 32'h0000_0000, 32'h0000_0000);
        lit_reg(5'd8, 32'h0000_0000, 32'h0000_0000);
    endtask

    logic [5:0] fns [12];

    initial begin
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h21};
        for (int i = 0; i < 64; i++) prog[i] = 32'd0;
        #1;

        // Single instruction: retires in the cycle after the fourth edge.
        prog[0] = rinst(6'h27, 5'd0, 5'd0, 5'd1, 5'd0);
        do_reset();
        cyc(1'b0, 1'b0, 1'b1, 2, 5'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 3, 5'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 3, 5'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 3, 5'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 3, 5'd0, 32'd1, 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1, 5'd1, 32'hFFFF_FFFF, 32'h0000_FFFF);

        // Back-to-back dependent chain, shifts, compares, no-write cases.
        load_chain(5'd28);
        do_reset();
        run(1'b0, 1'b1, 16);
        check_chain28();

        // Same program with a stall burst and fetch bubbles.
        do_reset();
        run(1'b0, 1'b1, 3);
        run(1'b1, 1'b1, 3);
        run(1'b0, 1'b1, 2);
        run(1'b0, 1'b0, 2);
        run(1'b0, 1'b1, 16);
        check_chain28();

        // Reset with instructions in flight.
        do_reset();
        run(1'b0, 1'b1, 5);
        cyc(1'b0, 1'b0, 1'b1, 1, 5'd1, 32'hFFFF_FFFF, 32'h0000_FFFF);
        cyc(1'b1, 1'b0, 1'b1, 0, 5'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 2, 5'd0, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1, 5'd1, 32'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 3, 5'd0, 32'd0, 32'd0);

        // Narrow-datapath chain: srl by 12.
        load_chain(5'd12);
        do_reset();
        run(1'b0, 1'b1, 16);
        lit_reg(5'd1, 32'hFFFF_FFFF, 32'h0000_FFFF);
        lit_reg(5'd2, 32'h000F_FFFF, 32'h0000_000F);
        lit_reg(5'd3, 32'h001F_FFFE, 32'h0000_001E);
        lit_reg(5'd4, 32'h001F_FFFF, 32'h0000_001F);

        // Randomised streams with stalls, bubbles and occasional resets.
        for (int round = 0; round < 3; round++) begin
            for (int i = 0; i < 64; i++) begin
                logic [5:0] op;
                logic [4:0] rs, rt, rd;
                op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
                rs = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                rt = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                rd = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
                prog[i] = {op, rs, rt, rd, 5'($urandom), fns[$urandom_range(0, 11)]};
            end
            do_reset();
            for (int i = 0; i < 400; i++)
                cyc(($urandom_range(0, 149) == 0), ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 5) != 0), 0, 5'd0, 32'd0, 32'd0);
            run(1'b0, 1'b0, 6);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/r_pipeline_core.md
Name: r_pipeline_core

Overview:
- Parametrised successor to the fixed 32-bit R-type pipeline.
- Five-stage in-order R-type core: fetch, decode/register read, execute, memory passthrough, write-back.
- Generalised in data width and register count; adds a PC register, per-stage valid bits, full EX operand forwarding, RF write-through, a global stall, fetch bubbles, synchronous reset and a retire/debug interface.
- Sits between the instruction memory (combinational read) and testbench observation logic.

Parameters:
- XLEN, 32, datapath and register width (>=8).
- NREG, 32, architectural register count, power of two, <=32; register 0 reads as zero.
- PC_STEP, 4, PC increment per accepted instruction.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  32  current PC, drives instruction memory.
- imem_instr  in  32  instruction at imem_addr (combinational).
- imem_valid  in  1  imem_instr is valid this cycle.
- stall  in  1  freeze the whole pipeline.
- retire_valid  out  1  an instruction is in WB this cycle and writes.
- retire_rd  out  5  destination of the retiring instruction.
- retire_data  out  XLEN  value written.
- dbg_addr  in  5  debug register-read address.
- dbg_data  out  XLEN  combinational RF read; 0 for address 0 or >=NREG.

Behaviour:
- Reset (sampled at posedge while rst=1):
  - PC=0; all stage valid bits=0; all registers=0.
  - retire_valid=0; retire_rd=0; retire_data=0.
  - Overrides stall.
  - Reset mid-operation discards all in-flight instructions; no RF write occurs on the reset edge.
- Fetch:
  - If !stall && imem_valid: IF/ID captures imem_instr with valid=1, and PC += PC_STEP (wraps modulo 2^32).
  - If !stall && !imem_valid: IF/ID valid=0 (bubble); PC holds.
- Decode:
  - opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], shamt = [10:6], funct = [5:0].
  - Writes only when valid && opcode==0 && funct is supported && rd!=0 && rd<NREG; otherwise the instruction is a NOP with no write.
  - Any rs/rt >= NREG reads 0.
- ALU (XLEN-bit, results truncated, overflow ignored):
  - add 0x20 -> a+b; sub 0x22 -> a-b.
  - and 0x24; or 0x25; xor 0x26; nor 0x27.
  - slt 0x2A -> signed a<b ? 1 : 0; sltu 0x2B -> unsigned compare.
  - sll 0x00 -> b<<shamt; srl 0x02 -> b>>shamt logical; sra 0x03 -> b>>>shamt arithmetic.
  - Shift amounts >= XLEN yield 0 for sll/srl and sign fill for sra.
- Forwarding:
  - EX operand priority: EX/MEM result, then MEM/WB result, then the ID/EX latched value.
  - A source is forwarded only if the producer is valid, writes, and its rd equals rs/rt.
  - RF write-through: a WB write to the same register read in ID that cycle supplies the new value.
  - No stalls are ever required; back-to-back dependents get correct values.
- Latency:
  - Instruction accepted at edge E0 retires in the cycle after edge E3: retire_valid high, with the RF updated at edge E4.
  - One instruction per cycle sustained.
- Stall:
  - stall=1 holds PC, all pipeline registers and valid bits; no RF write occurs.
  - retire_valid = MEM/WB writes && !stall.
  - Release resumes exactly where frozen.
- Simultaneous events: rst > stall > fetch; a stall asserted with imem_valid=1 does not consume the instruction.

Test Plan:
- Independent stream: rst, then instructions `add $1,$0,$0` … with R1=0 and preload via `sub`/`nor` (`nor $1,$0,$0` gives R1=0xFFFFFFFF) -> retire_valid 4 cycles after acceptance; dbg_data(1)=0xFFFFFFFF.
- Forward chain: `nor $1,$0,$0`; `srl $2,$1,28`; `add $3,$2,$2`; `sub $4,$3,$1` back-to-back -> R2=0xF, R3=0x1E, R4=0x1F; no bubbles.
- Shifts and compares: R1=0xFFFFFFFF -> `sra $5,$1,31`=0xFFFFFFFF; `slt $6,$1,$0`=1; `sltu $7,$1,$0`=0.
- Writes to $0 and non-R opcode 0x23 -> retire_valid stays 0; dbg_data(0)=0.
- Stall: assert stall for 3 cycles mid-stream with imem_valid=1 -> PC frozen, no retire, final registers identical to the unstalled run; imem_valid=0 for 2 cycles -> 2 bubbles, PC holds.
- Reset mid-flight: rst with 3 instructions in flight -> PC=0, retire_valid=0 the next cycle, registers all 0; XLEN=16, NREG=8 rerun of the forward chain -> R4=0x1F masked to 16 bits (R1=0xFFFF, R2=0xF under srl 12).
